arf_sequencer: RTL

ARF_SEQUENCER -- requirements
Module: arf_sequencer

---
 rtl/arf_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/arf_sequencer.sv
// Command sequencer for an address register file (PC/SP/AR): turns FETCH/PUSH/POP/load/clear
// commands into one- or two-step register enables and memory address strobes.
module arf_sequencer #(
   parameter int unsigned STACK_DEPTH = 16
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        CmdValid,
   output logic        CmdReady,
   input  logic [2:0]  CmdOp,
   input  logic [15:0] CmdData,
   output logic [15:0] I,
   output logic [1:0]  FunSel,
   output logic [2:0]  RegSel,
   output logic [1:0]  OutCSel,
   output logic [1:0]  OutDSel,
   output logic        AddrStrobe,
   output logic        Done,
   output logic        Err
);

   localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_FETCH  = 3'b001;
   localparam logic [2:0] OP_PUSH   = 3'b010;
   localparam logic [2:0] OP_POP    = 3'b011;
   localparam logic [2:0] OP_LDPC   = 3'b100;
   localparam logic [2:0] OP_LDAR   = 3'b101;
   localparam logic [2:0] OP_LDSP   = 3'b110;
   localparam logic [2:0] OP_CLRALL = 3'b111;

   typedef enum logic [1:0] {IDLE, STEP1, STEP2, DONE} state_t;

   typedef struct packed {
      logic [15:0] i;
      logic [1:0]  funsel;
      logic [2:0]  regsel;
      logic [1:0]  outsel;
      logic        strobe;
   } drive_t;

   // Register-file controls for one step of a command; all-zero is the idle drive.
   function automatic drive_t step_drive(input logic [2:0] op, input logic [15:0] data,
                                         input logic second);
      drive_t d;
      d = '0;
      case (op)
         OP_FETCH: if (!second) begin
            d.outsel = 2'b00;
            d.strobe = 1'b1;
            d.regsel = 3'b100;
            d.funsel = 2'b01;
         end
         OP_PUSH: begin
            if (!second) begin
               d.outsel = 2'b01;
               d.strobe = 1'b1;
            end else begin
               d.regsel = 3'b010;
               d.funsel = 2'b00;
            end
         end
         OP_POP: begin
            if (!second) begin
               d.regsel = 3'b010;
               d.funsel = 2'b01;
            end else begin
               d.outsel = 2'b01;
               d.strobe = 1'b1;
            end
         end
         OP_LDPC: if (!second) begin
            d.i      = data;
            d.funsel = 2'b10;
            d.regsel = 3'b100;
         end
         OP_LDAR: if (!second) begin
            d.i      = data;
            d.funsel = 2'b10;
            d.regsel = 3'b001;
         end
         OP_LDSP: if (!second) begin
            d.i      = data;
            d.funsel = 2'b10;
            d.regsel = 3'b010;
         end
         OP_CLRALL: if (!second) begin
            d.regsel = 3'b111;
            d.funsel = 2'b11;
         end
         default: d = '0;
      endcase
      return d;
   endfunction

   state_t             state_q;
   logic [2:0]         op_q;
   logic [15:0]        data_q;
   logic [DEPTH_W-1:0] depth_q;
   logic               err_q;
   logic               done_q;
   drive_t             drive_q;
   logic               fault;
   logic               two_step;

   // Overflow/underflow is decided at accept; Depth cannot move while a command is in flight.
   always_comb begin
      fault = ((CmdOp == OP_PUSH) && (depth_q == DEPTH_MAX)) ||
              ((CmdOp == OP_POP) && (depth_q == '0));
      two_step = ((op_q == OP_PUSH) || (op_q == OP_POP)) && !err_q;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         data_q  <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         drive_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (CmdValid) begin
                  op_q    <= CmdOp;
                  data_q  <= CmdData;
                  err_q   <= fault;
                  drive_q <= fault ? drive_t'('0) : step_drive(CmdOp, CmdData, 1'b0);
                  state_q <= STEP1;
               end
            end
            STEP1: begin
               // POP moves SP in its first step, LDSP/CLRALL reset the stack outright.
               if ((op_q == OP_POP) && !err_q) depth_q <= depth_q - DEPTH_W'(1);
               if ((op_q == OP_LDSP) || (op_q == OP_CLRALL)) depth_q <= '0;
               if (two_step) begin
                  drive_q <= step_drive(op_q, data_q, 1'b1);
                  state_q <= STEP2;
               end else begin
                  drive_q <= '0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            STEP2: begin
               if (op_q == OP_PUSH) depth_q <= depth_q + DEPTH_W'(1);
               drive_q <= '0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset must idle the register file within the same cycle, so drives are gated combinationally.
   always_comb begin
      CmdReady   = (state_q == IDLE) && !Reset;
      I          = Reset ? 16'h0000 : drive_q.i;
      FunSel     = Reset ? 2'b00 : drive_q.funsel;
      RegSel     = Reset ? 3'b000 : drive_q.regsel;
      OutDSel    = Reset ? 2'b00 : drive_q.outsel;
      OutCSel    = OutDSel;
      AddrStrobe = Reset ? 1'b0 : drive_q.strobe;
      Done       = done_q;
      Err        = done_q & err_q;
   end

endmodule
